mult_div_unit: RTL

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It sits beside the ALU/shifter logic unit and consumes the same operand buses that feed it (register A and register B values). It produces the 64-bit HI/LO pair for MULT and DIV and raises a divide-by-zero flag for the exception path. The control unit starts an operation, waits on `busy`/`done`, then reads HI/LO through the existing write-back muxing.

---
 rtl/mult_div_unit_if.sv | 35 +++
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Operand / result bundle between the multicycle control path and the
// iterative multiply/divide unit.
//   SrcA, SrcB : operands (multiplicand/dividend, multiplier/divisor), signed
//   start, op  : request strobe and operation select (0 = MULT, 1 = DIV)
//   HI, LO     : result registers (product high/low, or remainder/quotient)
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   DIV_ZERO   : one-cycle pulse with done when a DIV had a zero divisor
// master = requester (control unit / bench), slave = mult_div_unit.
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             DIV_ZERO;

    modport master (
        output SrcA, SrcB, start, op,
        input  HI, LO, busy, done, DIV_ZERO
    );

    modport slave (
        input  SrcA, SrcB, start, op,
        output HI, LO, busy, done, DIV_ZERO
    );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative signed MULT / DIV unit producing the HI/LO pair for the multicycle
// MIPS datapath.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears control state and HI/LO
//   bus    : mult_div_unit_if.slave (operands, start/op, HI/LO, busy, done,
//            DIV_ZERO)
// MULT: radix-2 Booth, WIDTH iterations over a {acc, multiplier, q-1} register.
// DIV : restoring division on operand magnitudes, WIDTH iterations, followed by
//       a sign fix (quotient truncates toward zero, remainder follows dividend).
// Latency: result and done one edge after the last iteration (33 edges after
// the start edge for WIDTH = 32); divide-by-zero completes after one edge.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int W  = WIDTH;
    localparam int RW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Control state (reset)
    state_t         state_q,    state_d;
    logic [5:0]     cnt_q,      cnt_d;
    logic [W-1:0]   hi_q,       hi_d;
    logic [W-1:0]   lo_q,       lo_d;
    logic           done_q,     done_d;
    logic           dz_q,       dz_d;

    // Datapath working registers (loaded on every accepted start, no reset)
    logic [RW-1:0]  work_q,     work_d;     // MULT: {acc, mplier, q-1}; DIV: {0, rem, quot}
    logic [W-1:0]   mcand_q,    mcand_d;    // MULT: multiplicand; DIV: |divisor|
    logic           neg_quot_q, neg_quot_d;
    logic           neg_rem_q,  neg_rem_d;
    logic           bzero_q,    bzero_d;

    logic           take_start;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1),
    // which is still representable as an unsigned W-bit number.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // One Booth step. The add/subtract is done one bit wider than acc so the
    // shift-in bit is correct even when the multiplicand is -2^(W-1); the
    // shifted result then fits back into the W-bit accumulator.
    function automatic logic [RW-1:0] booth_step(input logic [RW-1:0] r, input logic [W-1:0] m);
        logic signed [W:0] acc_x;
        logic signed [W:0] m_x;
        logic signed [W:0] sum;
        acc_x = signed'({r[RW-1], r[RW-1:W+1]});
        m_x   = signed'({m[W-1], m});
        case (r[1:0])
            2'b01:   sum = acc_x + m_x;
            2'b10:   sum = acc_x - m_x;
            default: sum = acc_x;
        endcase
        return {sum, r[W:1]};
    endfunction

    // One restoring-division step: shift {rem, quot} left, trial-subtract the
    // divisor from the (W+1)-bit shifted remainder, record the quotient bit.
    // When the subtraction succeeds the true difference is below 2^W, so the
    // low W bits of a W-bit subtract are exact.
    function automatic logic [RW-1:0] div_step(input logic [RW-1:0] r, input logic [W-1:0] d);
        logic [W:0]   rem_sh;
        logic [W-1:0] diff;
        logic         take;
        rem_sh = r[2*W-1:W-1];
        take   = (rem_sh >= {1'b0, d});
        diff   = rem_sh[W-1:0] - d;
        return {r[RW-1], (take ? diff : rem_sh[W-1:0]), r[W-2:0], take};
    endfunction

    // A start is accepted in IDLE and also on the edge that leaves DONE, so
    // back-to-back operations issue every 34 cycles.
    assign take_start = bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_d       = 1'b0;
        work_d     = work_q;
        mcand_d    = mcand_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        bzero_d    = bzero_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MULT: begin
                if (cnt_q == 6'(W)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hi_d    = work_q[RW-1:W+1];
                    lo_d    = work_q[W:1];
                end else begin
                    work_d = booth_step(work_q, mcand_q);
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            DIV: begin
                if (bzero_q) begin
                    // HI/LO keep their previous values on divide-by-zero.
                    state_d = DONE;
                    done_d  = 1'b1;
                    dz_d    = 1'b1;
                end else if (cnt_q == 6'(W)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hi_d    = apply_sign(work_q[2*W-1:W], neg_rem_q);
                    lo_d    = apply_sign(work_q[W-1:0], neg_quot_q);
                end else begin
                    work_d = div_step(work_q, mcand_q);
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_start) begin
            cnt_d = 6'd0;
            if (!bus.op) begin
                state_d = MULT;
                mcand_d = bus.SrcA;
                work_d  = {{W{1'b0}}, bus.SrcB, 1'b0};
            end else begin
                state_d    = DIV;
                mcand_d    = magnitude(bus.SrcB);
                work_d     = {{(W+1){1'b0}}, magnitude(bus.SrcA)};
                neg_quot_d = bus.SrcA[W-1] ^ bus.SrcB[W-1];
                neg_rem_d  = bus.SrcA[W-1];
                bzero_d    = (bus.SrcB == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        work_q     <= work_d;
        mcand_q    <= mcand_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
        bzero_q    <= bzero_d;
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = (state_q == MULT) || (state_q == DIV);
    assign bus.done     = done_q;
    assign bus.DIV_ZERO = dz_q;

endmodule
